// File: rtl/value_text_display.sv
// value_text_display: samples a value on a periodic tick, converts it to decimal with an
// iterative double-dabble and serves "LABEL + digits" to the character generator.
//   state   | meaning
//   IDLE    | waiting for a sample tick
//   CONVERT | one double-dabble iteration per clock
//   FORMAT  | buffer is rewritten atomically from the BCD result or overflow text
module value_text_display #(
    parameter int          VALUE_WIDTH = 12,
    parameter int          DIGITS      = 4,
    parameter int          MAX_VALUE   = 377,
    parameter int          TICK_DIV    = 25000000,
    parameter int          TEXT_LINE   = 2,
    parameter int          TEXT_COL    = 0,
    parameter logic [31:0] LABEL       = "FIB:",
    parameter logic [31:0] OVF_TEXT    = "DONE"
) (
    input  logic                   pixel_clock,
    input  logic                   reset,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic [6:0]             char_line,
    input  logic [6:0]             char_column,
    output logic [7:0]             char_write_data,
    output logic                   busy,
    output logic                   update_done
);
    localparam int FL = 4 + DIGITS;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(TICK_DIV + 1);
    localparam int IW = $clog2(VALUE_WIDTH + 1);
    localparam int AW = (FL > 1) ? $clog2(FL) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [31:0]   MAXV      = MAX_VALUE;
    localparam logic [7:0]    SPACE     = 8'h20;
    localparam logic [7:0]    COL_LO    = 8'(TEXT_COL);
    localparam logic [7:0]    COL_HI    = 8'(TEXT_COL + FL);
    localparam logic [6:0]    LINE      = 7'(TEXT_LINE);

    typedef enum logic [1:0] {IDLE, CONVERT, FORMAT} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          tick_count;
    logic                   tick;
    logic                   over_max;
    logic [VALUE_WIDTH-1:0] shift;
    logic [BW-1:0]          bcd;
    logic [BW-1:0]          bcd_adj;
    logic [BW-1:0]          bcd_packed;
    logic [IW-1:0]          iter;
    logic                   ovf;
    logic [7:0]             buffer [FL];
    logic [7:0]             fmt    [FL];
    int                     lead;
    logic                   leading;
    logic [7:0]             col_ext;
    logic                   in_field;
    logic [AW-1:0]          offset;

    assign tick     = (tick_count == TICK_LAST);
    assign over_max = (32'(value) > MAXV);
    assign busy     = (state != IDLE);

    always_ff @(posedge pixel_clock) begin
        if (reset || tick) tick_count <= '0;
        else               tick_count <= tick_count + CW'(1);
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = over_max ? FORMAT : CONVERT;
            CONVERT: if (iter == IW'(1)) state_next = FORMAT;
            FORMAT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            shift <= '0;
            bcd   <= '0;
            iter  <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (tick) begin
                    shift <= value;
                    bcd   <= '0;
                    iter  <= IW'(VALUE_WIDTH);
                    ovf   <= over_max;
                end
                CONVERT: begin
                    {bcd, shift} <= {bcd_adj, shift} << 1;
                    iter         <= iter - IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Leading zeros are dropped by shifting the BCD word up; the last digit always shows.
    always_comb begin
        lead    = 0;
        leading = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (leading && bcd[4*i +: 4] == 4'd0) lead = lead + 1;
            else                                  leading = 1'b0;
        end
        bcd_packed = bcd << (4 * lead);
        for (int p = 0; p < 4; p++) begin
            fmt[p] = ovf ? OVF_TEXT[8*(3-p) +: 8] : LABEL[8*(3-p) +: 8];
        end
        for (int p = 0; p < DIGITS; p++) begin
            if (!ovf && p < DIGITS - lead) fmt[4+p] = {4'h3, bcd_packed[4*(DIGITS-1-p) +: 4]};
            else                           fmt[4+p] = SPACE;
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            update_done <= 1'b0;
            for (int i = 0; i < FL; i++) buffer[i] <= SPACE;
        end else begin
            update_done <= (state == FORMAT);
            if (state == FORMAT) begin
                for (int i = 0; i < FL; i++) buffer[i] <= fmt[i];
            end
        end
    end

    assign col_ext  = {1'b0, char_column};
    assign in_field = (char_line == LINE) && (col_ext >= COL_LO) && (col_ext < COL_HI);
    assign offset   = AW'(char_column - COL_LO[6:0]);

    always_ff @(posedge pixel_clock) begin
        if (reset)         char_write_data <= SPACE;
        else if (in_field) char_write_data <= buffer[offset];
        else               char_write_data <= SPACE;
    end
endmodule

// File: tb/tb_value_text_display.sv
// Bench for value_text_display: randomized values checked against a string-formatting model.
module tb_value_text_display;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [3];
    logic [11:0] val  [3];
    logic [7:0]  rd   [3];
    logic        bsy  [3];
    logic        done [3];
    logic [6:0]  line;
    logic [6:0]  col;

    int checks = 0;
    int errors = 0;

    value_text_display #(.TICK_DIV(32)) dut_a (
        .pixel_clock(clk), .reset(rst[0]), .value(val[0]), .char_line(line),
        .char_column(col), .char_write_data(rd[0]), .busy(bsy[0]), .update_done(done[0]));

    value_text_display #(.TICK_DIV(32), .MAX_VALUE(4095), .TEXT_COL(10)) dut_b (
        .pixel_clock(clk), .reset(rst[1]), .value(val[1]), .char_line(line),
        .char_column(col), .char_write_data(rd[1]), .busy(bsy[1]), .update_done(done[1]));

    value_text_display #(.TICK_DIV(4)) dut_c (
        .pixel_clock(clk), .reset(rst[2]), .value(val[2]), .char_line(line),
        .char_column(col), .char_write_data(rd[2]), .busy(bsy[2]), .update_done(done[2]));

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, want, want);
        end
    endtask

    // Expected field text: label plus decimal digits padded to 8 chars, or the overflow text.
    function automatic string model_text(input int v, input int maxv);
        string s;
        if (v > maxv) s = "DONE";
        else          s = $sformatf("FIB:%0d", v);
        while (s.len() < 8) s = {s, " "};
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_char(input int sel, input int ln, input int c, output int got);
        line = 7'(ln);
        col  = 7'(c);
        step();
        got = int'(rd[sel]);
    endtask

    task automatic run_conv(input int sel, input int v, input int maxv, input int col0);
        int    first_done;
        int    n_done;
        int    n_busy;
        int    lat;
        int    got;
        string want;
        first_done = -1;
        n_done     = 0;
        n_busy     = 0;
        rst[sel]   = 1'b1;
        val[sel]   = 12'(v);
        step();
        check($sformatf("reset_busy v=%0d", v), int'(bsy[sel]), 0);
        check($sformatf("reset_done v=%0d", v), int'(done[sel]), 0);
        check($sformatf("reset_char v=%0d", v), int'(rd[sel]), 32);
        rst[sel] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 34) val[sel] = 12'($urandom);
            if (k == 50) val[sel] = 12'(v);
            if (done[sel]) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            if (bsy[sel]) n_busy++;
        end
        lat = (v > maxv) ? 1 : 13;
        check($sformatf("done_latency v=%0d", v), first_done, 32 + lat);
        check($sformatf("done_pulses v=%0d", v), n_done, 1);
        check($sformatf("busy_cycles v=%0d", v), n_busy, lat);
        want = model_text(v, maxv);
        for (int p = 0; p < 8; p++) begin
            read_char(sel, 2, col0 + p, got);
            check($sformatf("char[%0d] v=%0d", col0 + p, v), got, int'(want[p]));
        end
        read_char(sel, 2, col0 + 8, got);
        check($sformatf("after_field v=%0d", v), got, 32);
        if (col0 > 0) begin
            read_char(sel, 2, col0 - 1, got);
            check($sformatf("before_field v=%0d", v), got, 32);
        end
        read_char(sel, 3, col0 + 2, got);
        check($sformatf("wrong_line v=%0d", v), got, 32);
    endtask

    initial begin
        int    got;
        int    seen;
        int    last;
        int    n;
        int    first;
        string want;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            val[i] = '0;
        end
        line = 7'd2;
        col  = 7'd0;

        run_conv(0, 144, 377, 0);
        run_conv(0, 0, 377, 0);
        run_conv(0, 233, 377, 0);
        run_conv(0, 400, 377, 0);
        run_conv(0, 377, 377, 0);
        run_conv(0, 378, 377, 0);
        for (int r = 0; r < 5; r++) run_conv(0, int'($urandom_range(0, 450)), 377, 0);
        run_conv(1, 4095, 4095, 10);
        for (int r = 0; r < 2; r++) run_conv(1, int'($urandom_range(0, 4095)), 4095, 10);

        // Fast ticks with a held value: dropped ticks give a 16-cycle period, no partial buffer.
        want   = model_text(89, 377);
        rst[2] = 1'b1;
        val[2] = 12'd89;
        line   = 7'd2;
        col    = 7'd0;
        step();
        rst[2] = 1'b0;
        seen   = 0;
        last   = -1;
        n      = 0;
        for (int k = 1; k <= 70; k++) begin
            step();
            check($sformatf("fast_char k=%0d", k), int'(rd[2]),
                  (seen != 0) ? int'(want[(k - 1) % 8]) : 32);
            if (done[2]) begin
                if (last < 0) check("fast_first_done", k, 17);
                else          check($sformatf("fast_period k=%0d", k), k - last, 16);
                last = k;
                n++;
                seen = 1;
            end
            col = 7'(k % 8);
        end
        check("fast_done_count", n, 4);

        // Reset lands five edges into the second conversion of 377.
        want   = model_text(377, 377);
        rst[0] = 1'b1;
        val[0] = 12'd377;
        line   = 7'd2;
        col    = 7'd0;
        step();
        rst[0] = 1'b0;
        for (int k = 1; k <= 68; k++) step();
        check("pre_reset_char", int'(rd[0]), int'(want[0]));
        rst[0] = 1'b1;
        step();
        check("mid_reset_char", int'(rd[0]), 32);
        check("mid_reset_busy", int'(bsy[0]), 0);
        rst[0] = 1'b0;
        first  = -1;
        n      = 0;
        for (int k = 70; k <= 130; k++) begin
            step();
            if (k == 70) check("post_reset_buffer", int'(rd[0]), 32);
            if (done[0]) begin
                n++;
                if (first < 0) first = k;
            end
        end
        check("post_reset_first_done", first, 114);
        check("post_reset_done_count", n, 1);
        for (int p = 0; p < 8; p++) begin
            read_char(0, 2, p, got);
            check($sformatf("post_reset_char[%0d]", p), got, int'(want[p]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
